led_pattern_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 24 ++
 rtl/led_step_src.sv | 44 ++++
 rtl/led_pattern_sequencer.sv | 157 +++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: step modes, FSM phases and
// a counter-width helper.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BINUP  = 2'd2,
    MODE_BINDN  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PH_FILL  = 2'd0,
    PH_DRAIN = 2'd1,
    PH_UP    = 2'd2,
    PH_DOWN  = 2'd3
  } phase_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_step_src.sv
// Step source: debounced-button falling-edge detect OR'd with an auto-step
// prescaler tick; a coincident edge and tick yield a single step.
module led_step_src
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic btn_valid_i,
  input  logic auto_en_i,
  output logic step_o
);

  localparam int CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic          prev_btn_q;
  logic [CW-1:0] pre_q, pre_d;
  logic          tick;

  // Prescaler parks at zero whenever auto-stepping is off.
  always_comb begin
    tick  = auto_en_i && (pre_q == TERM);
    pre_d = '0;
    if (auto_en_i && !tick) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_btn_q <= 1'b0;
      pre_q      <= '0;
    end else begin
      prev_btn_q <= btn_i;
      pre_q      <= pre_d;
    end
  end

  assign step_o = (btn_valid_i & prev_btn_q & ~btn_i) | tick;

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: fill/drain, bounce, binary up/down patterns stepped by
// button edges or auto ticks. Optional PWM dimming when LED_DIM_EN is defined.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_COUNT   = 8,
  parameter int ACTIVE_LOW  = 1,
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int STEP_HZ     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn,
  input  logic                 btn_valid,
  input  logic [1:0]           mode,
  input  logic                 auto_en,
`ifdef LED_DIM_EN
  input  logic [3:0]           dim_duty,
`endif
  output logic [LED_COUNT-1:0] led_out,
  output logic                 step_strobe,
  output logic                 wrap
);

  localparam int TICK_DIV = CLK_FREQ_HZ / STEP_HZ;
  localparam int POS_W    = cnt_width(LED_COUNT);
  localparam logic [POS_W-1:0]     LAST_POS = POS_W'(LED_COUNT - 1);
  localparam logic [LED_COUNT-1:0] LED_OFF  = (ACTIVE_LOW != 0) ? {LED_COUNT{1'b1}} : '0;

  logic                 step;
  logic [LED_COUNT-1:0] pat_q, pat_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  phase_e               phase_q, phase_d;
  mode_e                mode_q, mode_d;
  logic                 loaded_q;
  logic                 strobe_d, wrap_d;
  logic [LED_COUNT-1:0] led_q, lit;
  logic                 strobe_q, wrap_q;
  logic                 pwm_on;

  led_step_src #(.TICK_DIV(TICK_DIV)) u_step_src (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (btn),
    .btn_valid_i(btn_valid),
    .auto_en_i  (auto_en),
    .step_o     (step)
  );

  // The first clock after reset only latches the mode, exactly like a mode change.
  always_comb begin
    pat_d    = pat_q;
    pos_d    = pos_q;
    phase_d  = phase_q;
    mode_d   = mode_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
    if (!loaded_q || (mode != mode_q)) begin
      mode_d  = mode_e'(mode);
      pat_d   = '0;
      pos_d   = '0;
      phase_d = (mode_e'(mode) == MODE_BOUNCE) ? PH_UP : PH_FILL;
    end else if (step) begin
      strobe_d = 1'b1;
      case (mode_q)
        MODE_FILL: begin
          if (phase_q == PH_DRAIN) begin
            pat_d[LAST_POS - pos_q] = 1'b0;
            if (pos_q == LAST_POS) begin
              wrap_d  = 1'b1;
              phase_d = PH_FILL;
              pos_d   = '0;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            pat_d[pos_q] = 1'b1;
            if (pos_q == LAST_POS) begin
              phase_d = PH_DRAIN;
              pos_d   = '0;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
        end
        MODE_BOUNCE: begin
          if (pat_q == '0) begin
            pat_d   = {{(LED_COUNT-1){1'b0}}, 1'b1};
            pos_d   = '0;
            phase_d = PH_UP;
          end else if (phase_q == PH_UP) begin
            pat_d = pat_q << 1;
            pos_d = pos_q + 1'b1;
            if (pos_d == LAST_POS) phase_d = PH_DOWN;
          end else begin
            pat_d = pat_q >> 1;
            pos_d = pos_q - 1'b1;
            if (pos_d == '0) begin
              phase_d = PH_UP;
              wrap_d  = 1'b1;
            end
          end
        end
        MODE_BINUP: begin
          pat_d  = pat_q + 1'b1;
          wrap_d = (pat_d == '0);
        end
        MODE_BINDN: begin
          pat_d  = pat_q - 1'b1;
          wrap_d = &pat_d;
        end
      endcase
    end
  end

`ifdef LED_DIM_EN
  logic [3:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= 4'd0;
    else        pwm_cnt_q <= pwm_cnt_q + 4'd1;
  end

  assign pwm_on = (pwm_cnt_q < dim_duty);
`else
  assign pwm_on = 1'b1;
`endif

  assign lit = pat_d & {LED_COUNT{pwm_on}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q    <= '0;
      pos_q    <= '0;
      phase_q  <= PH_FILL;
      mode_q   <= MODE_FILL;
      loaded_q <= 1'b0;
      led_q    <= LED_OFF;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      pos_q    <= pos_d;
      phase_q  <= phase_d;
      mode_q   <= mode_d;
      loaded_q <= 1'b1;
      led_q    <= (ACTIVE_LOW != 0) ? ~lit : lit;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end

  assign led_out     = led_q;
  assign step_strobe = strobe_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer (N=8, active-low, tick every 4 clocks):
// the driver predicts each registered update from a closed-form pattern model.
module tb_led_pattern_sequencer;

  localparam int N  = 8;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn = 1'b0;
  logic         btn_valid = 1'b0;
  logic         auto_en = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] led_out;
  logic         step_strobe;
  logic         wrap;

  led_pattern_sequencer #(
    .LED_COUNT(N), .ACTIVE_LOW(1), .CLK_FREQ_HZ(TD), .STEP_HZ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .btn_valid(btn_valid),
    .mode(mode), .auto_en(auto_en),
    .led_out(led_out), .step_strobe(step_strobe), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] led;
    logic         strb;
    logic         wrp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: mode in force, steps into the current period,
  // binary counter value, last btn level and prescaler count.
  int   m_mq, m_k, m_bv, m_pc;
  bit   m_ok;
  logic m_prev;

  task automatic model_clear();
    m_ok = 0; m_mq = 0; m_k = 0; m_bv = 0; m_pc = 0; m_prev = 1'b0;
  endtask

  // Pattern after the next step, derived from step counts within a period.
  task automatic model_advance(output logic [N-1:0] p, output bit w);
    int v, mm, pos;
    w = 0; v = 0;
    case (m_mq)
      0: begin
        m_k = m_k + 1;
        if (m_k == 2 * N) begin w = 1; m_k = 0; end
        v = (m_k <= N) ? ((1 << m_k) - 1) : ((1 << (2 * N - m_k)) - 1);
      end
      1: begin
        m_k = m_k + 1;
        mm  = (m_k - 1) % (2 * N - 2);
        pos = (mm < N) ? mm : (2 * N - 2 - mm);
        if (m_k > 1 && pos == 0) begin w = 1; m_k = 1; end
        v = 1 << pos;
      end
      2: begin
        m_bv = (m_bv + 1) % (1 << N);
        w = (m_bv == 0);
        v = m_bv;
      end
      default: begin
        m_bv = (m_bv + (1 << N) - 1) % (1 << N);
        w = (m_bv == (1 << N) - 1);
        v = m_bv;
      end
    endcase
    p = N'(v);
  endtask

  // Apply one cycle of inputs at a falling edge and queue the expected update.
  task automatic drive(input logic b, input logic v, input logic [1:0] md, input logic a);
    logic         edge_s, tick;
    logic [N-1:0] p;
    bit           w;
    exp_t         e;
    btn = b; btn_valid = v; mode = md; auto_en = a;
    edge_s = v && m_prev && !b;
    tick = 1'b0;
    if (a) begin
      tick = (m_pc == TD - 1);
      m_pc = tick ? 0 : m_pc + 1;
    end else begin
      m_pc = 0;
    end
    m_prev = b;
    if (!m_ok) begin
      m_ok = 1; m_mq = int'(md); m_k = 0; m_bv = 0;
    end else if (int'(md) != m_mq) begin
      m_mq = int'(md); m_k = 0; m_bv = 0;
      e.cyc = cyc + 1; e.led = '1; e.strb = 1'b0; e.wrp = 1'b0;
      q.push_back(e);
    end else if (edge_s || tick) begin
      model_advance(p, w);
      e.cyc = cyc + 1; e.led = ~p; e.strb = 1'b1; e.wrp = w;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic press(input logic [1:0] md);
    drive(1'b1, 1'b1, md, 1'b0);
    drive(1'b0, 1'b1, md, 1'b0);
  endtask

  // Assert reset between clock edges, check it bites at once, release on a falling edge.
  task automatic do_reset(input logic b);
    #3;
    rst_n = 1'b0; btn = b; btn_valid = 1'b1;
    #1;
    tests++;
    if (led_out !== '1 || step_strobe !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: led=%h strobe=%b wrap=%b, want led=ff strobe=0 wrap=0",
               led_out, step_strobe, wrap);
    end
    q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every falling edge out of reset, pop the entry due this cycle or
  // demand that no strobe/wrap is showing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          tests++; fails++;
          $display("FAIL missed_update: cycle %0d passed, want led=%h strobe=%b wrap=%b",
                   e.cyc, e.led, e.strb, e.wrp);
        end
        tests++;
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          if (led_out !== e.led || step_strobe !== e.strb || wrap !== e.wrp) begin
            fails++;
            $display("FAIL update@%0d: led=%h strobe=%b wrap=%b, want led=%h strobe=%b wrap=%b",
                     cyc, led_out, step_strobe, wrap, e.led, e.strb, e.wrp);
          end else begin
            $display("[TB] cyc %0d led=%h strobe=%b wrap=%b ok", cyc, led_out, step_strobe, wrap);
          end
        end else if (step_strobe !== 1'b0 || wrap !== 1'b0) begin
          fails++;
          $display("FAIL idle@%0d: strobe=%b wrap=%b, want strobe=0 wrap=0",
                   cyc, step_strobe, wrap);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       b, v, a;
    logic [1:0] md;
    model_clear();
    repeat (2) @(negedge clk);
    tests++;
    if (led_out !== 8'hFF || step_strobe !== 1'b0 || wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: led=%h strobe=%b wrap=%b, want led=ff strobe=0 wrap=0",
               led_out, step_strobe, wrap);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 2'd0, 1'b0);

    // Fill/drain: 17 edges cover a full period plus the restart.
    for (int i = 0; i < 17; i++) press(2'd0);

    // Bounce: 16 steps, wrap on arrival back at LED0.
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 16; i++) press(2'd1);

    // Binary down from reset, then a full binary-up period.
    do_reset(1'b0);
    drive(1'b0, 1'b1, 2'd3, 1'b0);
    press(2'd3);
    drive(1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 256; i++) press(2'd2);

    // Auto stepping with button edges landing on and off tick cycles.
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 24; i++) drive((i % 4) == 2, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 24; i++) drive(($urandom % 2) == 1, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, 2'd0, 1'b1);

    // Mode change coinciding with a button edge drops the step.
    do_reset(1'b0);
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) press(2'd0);
    drive(1'b1, 1'b1, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 1'b0);
    press(2'd1);

    // Reset mid-drain with the button held low through release.
    drive(1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 12; i++) press(2'd0);
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 2'd0, 1'b0);

    // Randomised traffic.
    md = 2'd0; a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      b = ($urandom % 2) == 1;
      v = ($urandom % 4) != 0;
      if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) a = ~a;
      drive(b, v, md, a);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, md, 1'b0);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_queue: %0d updates outstanding, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
